// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives one external expansion step per round,
// buffers the NR+1 round keys and serves them on a registered read port.
module key_sched_ctrl #(
   parameter int NR      = 10,
   parameter int TIMEOUT = 15
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [127:0] key_in,
   input  logic         key_valid,
   output logic         key_ready,
   output logic         dp_start,
   output logic [127:0] dp_key,
   output logic [7:0]   dp_rcon,
   input  logic         dp_done,
   input  logic [127:0] dp_rkey,
   input  logic [3:0]   rk_rd_addr,
   output logic [127:0] rk_rd_data,
   output logic         keys_valid,
   output logic         err
);

   localparam int                DATA_W  = 128;
   localparam int                CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [3:0]        NR_IDX  = 4'(NR);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [DATA_W-1:0]   cur;
   logic [7:0]          rcon;
   logic [3:0]          round;
   logic [CNT_W-1:0]    wcnt;
   logic [DATA_W-1:0]   rk [0:NR];

   logic                accept;
   logic                capture;
   logic                timeout;

   // Next Rcon is xtime() of the current one in GF(2^8).
   function automatic logic [7:0] rcon_next(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
   endfunction

   assign key_ready  = (state == S_IDLE) || (state == S_DONE);
   assign keys_valid = (state == S_DONE);
   assign dp_start   = (state == S_ISSUE);
   assign dp_key     = cur;
   assign dp_rcon    = rcon;

   assign accept  = key_valid && key_ready;
   assign capture = (state == S_WAIT) && dp_done;
   // A result arriving on the last allowed cycle takes precedence over the timeout.
   assign timeout = (state == S_WAIT) && !dp_done && (wcnt == TO_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) state_nxt = S_ISSUE;
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (capture)      state_nxt = (round == NR_IDX) ? S_DONE : S_ISSUE;
            else if (timeout) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cur        <= '0;
         rcon       <= 8'h01;
         round      <= 4'd0;
         wcnt       <= '0;
         err        <= 1'b0;
         rk_rd_data <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cur   <= key_in;
            rcon  <= 8'h01;
            round <= 4'd1;
            err   <= 1'b0;
         end
         if (state == S_ISSUE) wcnt <= '0;
         if (capture) begin
            cur <= dp_rkey;
            if (round != NR_IDX) begin
               round <= round + 4'd1;
               rcon  <= rcon_next(rcon);
            end
         end else if (state == S_WAIT) begin
            if (timeout) err  <= 1'b1;
            else         wcnt <= wcnt + 1'b1;
         end
         rk_rd_data <= (keys_valid && (rk_rd_addr <= NR_IDX)) ? rk[rk_rd_addr] : '0;
      end
   end

   // Round-key storage is deliberately not reset; keys_valid gates every read.
   always_ff @(posedge clock) begin
      if (accept)  rk[0]     <= key_in;
      if (capture) rk[round] <= dp_rkey;
   end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Bench for key_sched_ctrl: AES datapath responder with programmable latency,
// a cycle-level behavioural reference and literal FIPS-197 vectors.
module tb_key_sched_ctrl;

   localparam int NR = 10;

   logic         clock = 1'b0;
   logic         reset;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         dp_start;
   logic [127:0] dp_key;
   logic [7:0]   dp_rcon;
   logic         dp_done;
   logic [127:0] dp_rkey;
   logic [3:0]   rk_rd_addr;
   logic [127:0] rk_rd_data;
   logic         keys_valid;
   logic         err;

   key_sched_ctrl #(.NR(NR), .TIMEOUT(15)) dut (
      .clock(clock), .reset(reset), .key_in(key_in), .key_valid(key_valid),
      .key_ready(key_ready), .dp_start(dp_start), .dp_key(dp_key), .dp_rcon(dp_rcon),
      .dp_done(dp_done), .dp_rkey(dp_rkey), .rk_rd_addr(rk_rd_addr),
      .rk_rd_data(rk_rd_data), .keys_valid(keys_valid), .err(err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dp_delay = 1;
   bit spur = 1'b0;
   int pulse_cnt = 0;

   always @(posedge clock) cyc <= cyc + 1;

   logic [7:0] sbox [0:255] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   logic [7:0] rcon_tab [0:9] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

   function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = k;
      t  = {sbox[w3[23:16]] ^ rc, sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Datapath responder: dp_delay cycles after dp_start, 0 means it never answers.
   initial begin
      int cnt;
      logic [127:0] pend;
      cnt = 0;
      pend = '0;
      dp_done = 1'b0;
      dp_rkey = '0;
      forever begin
         @(negedge clock);
         dp_done = 1'b0;
         if (reset) cnt = 0;
         else begin
            if (cnt > 0) begin
               cnt--;
               if (cnt == 0) begin
                  dp_done = 1'b1;
                  dp_rkey = pend;
               end
            end
            if (dp_start && dp_delay > 0) begin
               pend = expand(dp_key, dp_rcon);
               cnt  = dp_delay;
            end
            if (spur) begin
               dp_done = 1'b1;
               dp_rkey = {$urandom, $urandom, $urandom, $urandom};
            end
         end
      end
   end

   // Reference: after an accept at edge A with latency D, every round lasts D+1
   // cycles; a silent datapath times out 16 edges after the accept.
   logic [127:0] exp_rk [0:NR];
   logic [127:0] prev_rd = '0;
   bit act = 0, mdone = 0, merr = 0;
   int acc = 0, acc_d = 1;

   initial begin
      int n, per, k;
      bit busy, exp_start;
      forever begin
         @(negedge clock);
         if (reset) begin
            act = 0; mdone = 0; merr = 0;
            chk("rst key_ready", key_ready, 1);
            chk("rst dp_start", dp_start, 0);
            chk("rst keys_valid", keys_valid, 0);
            chk("rst err", err, 0);
            chk("rst rd_data", rk_rd_data, 0);
            chk("rst dp_rcon", dp_rcon, 8'h01);
            chk("rst dp_key", dp_key, 0);
            prev_rd = '0;
         end else begin
            busy = 0; exp_start = 0; k = 0;
            if (act) begin
               n = cyc - acc;
               if (acc_d > 0) begin
                  per = acc_d + 1;
                  if (n < NR * per) begin
                     busy = 1; exp_start = (n % per) == 0; k = n / per;
                  end else begin
                     act = 0; mdone = 1;
                  end
               end else begin
                  if (n < 16) begin
                     busy = 1; exp_start = (n == 0);
                  end else begin
                     act = 0; merr = 1;
                  end
               end
            end
            chk("key_ready", key_ready, !busy);
            chk("keys_valid", keys_valid, mdone);
            chk("err", err, merr);
            chk("dp_start", dp_start, exp_start);
            if (dp_start) pulse_cnt++;
            if (exp_start) begin
               chk("dp_rcon", dp_rcon, rcon_tab[k]);
               chk("dp_key", dp_key, exp_rk[k]);
            end
            chk("rk_rd_data", rk_rd_data, prev_rd);
            prev_rd = (mdone && rk_rd_addr <= NR) ? exp_rk[rk_rd_addr] : '0;
            if (!busy && key_valid) begin
               acc = cyc + 1; acc_d = dp_delay; act = 1; mdone = 0; merr = 0;
               exp_rk[0] = key_in;
               for (int i = 1; i <= NR; i++) exp_rk[i] = expand(exp_rk[i-1], rcon_tab[i-1]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #2;
   endtask

   task automatic run_key(input logic [127:0] k, input int d);
      int i;
      for (i = 0; i < 300 && !key_ready; i++) tick(1);
      chk("ready before key", key_ready, 1);
      dp_delay  = d;
      key_in    = k;
      key_valid = 1'b1;
      tick(1);
      key_valid = 1'b0;
   endtask

   task automatic wait_kv(input int budget);
      int i;
      for (i = 0; i < budget && !keys_valid; i++) tick(1);
      chk("keys_valid within budget", keys_valid, 1);
   endtask

   task automatic read_chk(input logic [3:0] a, input logic [127:0] exp, input string name);
      rk_rd_addr = a;
      tick(1);
      chk(name, rk_rd_data, exp);
   endtask

   task automatic read_all();
      for (int a = 0; a < 16; a++) begin
         rk_rd_addr = 4'(a);
         tick(1);
      end
   endtask

   initial begin
      logic [127:0] fips_key;
      fips_key   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      reset      = 1'b1;
      key_valid  = 1'b0;
      key_in     = '0;
      rk_rd_addr = '0;
      tick(2);
      chk("lit reset key_ready", key_ready, 1);
      chk("lit reset dp_rcon", dp_rcon, 8'h01);
      reset = 1'b0;
      tick(2);

      // FIPS-197 vector with a one-cycle datapath
      pulse_cnt = 0;
      run_key(fips_key, 1);
      tick(19);
      chk("lit kv low at c20", keys_valid, 0);
      tick(1);
      chk("lit kv high at c21", keys_valid, 1);
      chk("lit pulse count", pulse_cnt, 10);
      read_chk(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, "lit rk1");
      read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "lit rk10");
      read_chk(4'd0, fips_key, "lit rk0");

      // stray dp_done while DONE must not disturb the buffer
      spur = 1'b1;
      tick(3);
      spur = 1'b0;
      read_all();
      read_chk(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "lit rk10 after stray done");

      // slow datapath with an ignored key_valid pulse mid-run
      run_key({$urandom, $urandom, $urandom, $urandom}, 5);
      tick(10);
      key_in = {$urandom, $urandom, $urandom, $urandom};
      key_valid = 1'b1;
      tick(1);
      key_valid = 1'b0;
      chk("lit busy key_ready", key_ready, 0);
      tick(48);
      chk("lit kv low at c60", keys_valid, 0);
      tick(1);
      chk("lit kv high at c61", keys_valid, 1);
      read_all();

      // rekey from DONE
      run_key(128'h000102030405060708090a0b0c0d0e0f, 1);
      chk("lit kv drops on rekey", keys_valid, 0);
      wait_kv(100);
      read_chk(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "lit rekey rk10");

      // silent datapath: timeout, then recovery
      run_key({$urandom, $urandom, $urandom, $urandom}, 0);
      tick(15);
      chk("lit err before timeout", err, 0);
      tick(1);
      chk("lit err after timeout", err, 1);
      chk("lit idle after timeout", key_ready, 1);
      chk("lit kv after timeout", keys_valid, 0);
      read_chk(4'd3, 128'h0, "lit read after timeout");
      run_key({$urandom, $urandom, $urandom, $urandom}, 3);
      chk("lit err cleared", err, 0);
      wait_kv(100);
      read_all();

      // result on the last allowed WAIT cycle beats the timeout
      run_key({$urandom, $urandom, $urandom, $urandom}, 15);
      wait_kv(200);
      chk("lit no err at limit", err, 0);
      read_all();

      // asynchronous reset during round 5
      run_key({$urandom, $urandom, $urandom, $urandom}, 1);
      tick(9);
      reset = 1'b1;
      #1;
      chk("lit async dp_rcon", dp_rcon, 8'h01);
      chk("lit async dp_key", dp_key, 0);
      chk("lit async key_ready", key_ready, 1);
      chk("lit async dp_start", dp_start, 0);
      tick(1);
      reset = 1'b0;
      run_key({$urandom, $urandom, $urandom, $urandom}, 2);
      wait_kv(100);
      for (int a = 11; a < 16; a++) read_chk(4'(a), 128'h0, "lit addr above NR");
      read_all();

      // randomized runs, some rekeyed straight from DONE
      for (int r = 0; r < 8; r++) begin
         run_key({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 15));
         wait_kv(200);
         for (int j = 0; j < 6; j++) begin
            rk_rd_addr = 4'($urandom_range(0, 15));
            tick(1);
         end
         if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
